// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the fractional clock-enable controller.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam int DEF_ACC_W      = 16;
    localparam int DEF_CNT_W      = 8;
    // 100 MHz base clock period, in picoseconds
    localparam int BASE_PERIOD_PS = 10000;

endpackage

// File: rtl/frac_phase_acc.sv
// Phase accumulator: adds inc each enabled cycle and registers the carry as the tick.
module frac_phase_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [ACC_W-1:0] inc,
    output logic [ACC_W-1:0] acc,
    output logic             carry,
    output logic             wrap
);

    logic [ACC_W:0] sum;

    // Full-width sum so a carry is never lost, even with inc = 2^ACC_W - 1
    assign sum  = {1'b0, acc} + {1'b0, inc};
    assign wrap = sum[ACC_W];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (run) begin
            acc   <= sum[ACC_W-1:0];
            carry <= sum[ACC_W];
        end else begin
            carry <= 1'b0;
        end
    end

endmodule

// File: rtl/frac_clk_div_ctrl.sv
// Fractional clock-enable generator with start/stop sequencing and
// tick-aligned, phase-continuous increment reconfiguration.
module frac_clk_div_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int               ACC_W   = DEF_ACC_W,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [ACC_W-1:0] RST_INC = 16'h8000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic [CNT_W-1:0] tick_cnt
);

    state_t           state;
    logic [ACC_W-1:0] inc_reg;
    logic [ACC_W-1:0] shadow;
    logic [ACC_W-1:0] acc;
    logic             wrap;
    logic             acc_clr;
    logic             cfg_hs;
    logic             cfg_ok;

    assign cfg_ready = (state != ST_PEND);
    assign busy      = (state != ST_IDLE);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign cfg_ok    = cfg_hs && (cfg_inc != '0);
    // Leaving or sitting in IDLE zeroes the phase and kills any pending carry
    assign acc_clr   = (state == ST_IDLE) || !en;

    frac_phase_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .run   (en),
        .inc   (inc_reg),
        .acc   (acc),
        .carry (tick),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (cfg_ok && state == ST_RUN && en) begin
            shadow <= cfg_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            inc_reg  <= RST_INC;
            clk_out  <= 1'b0;
            tick_cnt <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_hs && (cfg_inc == '0);
            case (state)
                ST_IDLE: begin
                    clk_out <= 1'b0;
                    if (cfg_ok) begin
                        inc_reg <= cfg_inc;
                    end
                    if (en) begin
                        state    <= ST_RUN;
                        tick_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        clk_out <= 1'b0;
                        if (cfg_ok) begin
                            inc_reg <= cfg_inc;
                        end
                    end else begin
                        if (wrap) begin
                            clk_out  <= ~clk_out;
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                        if (cfg_ok) begin
                            state <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        clk_out <= 1'b0;
                        inc_reg <= shadow;
                    end else if (wrap) begin
                        // Swap increment on the carry edge; residual phase carries over
                        state    <= ST_RUN;
                        inc_reg  <= shadow;
                        clk_out  <= ~clk_out;
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    logic unused_acc;
    assign unused_acc = ^acc;

endmodule

// File: tb/tb_frac_clk_div_ctrl.sv
// Randomized and directed bench for frac_clk_div_ctrl against a total-phase reference model.
module tb_frac_clk_div_ctrl;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
    localparam longint MODULUS = 64'd65536;

    logic             clk;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_ready;
    logic             cfg_err;
    logic             tick;
    logic             clk_out;
    logic             busy;
    logic [CNT_W-1:0] tick_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    frac_clk_div_ctrl #(
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W),
        .RST_INC (16'h8000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_inc   (cfg_inc),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .clk_out   (clk_out),
        .busy      (busy),
        .tick_cnt  (tick_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #(clk_ctrl_pkg::BASE_PERIOD_PS / 2000) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 running with pending config.
    // Ticks are found from the total phase crossing a multiple of 2^ACC_W.
    int     m_mode  = 0;
    longint m_phase = 0;
    int     m_inc   = 32'h8000;
    int     m_shadow = 0;
    bit     m_tick  = 0;
    bit     m_clk   = 0;
    int     m_cnt   = 0;
    bit     m_err   = 0;

    always @(posedge clk) begin
        bit hs, good, crossed;
        longint nxt;
        if (rst) begin
            m_mode = 0; m_phase = 0; m_inc = 32'h8000;
            m_tick = 0; m_clk = 0; m_cnt = 0; m_err = 0;
        end else begin
            hs    = cfg_valid && (m_mode != 2);
            good  = hs && (cfg_inc != 0);
            m_err = hs && (cfg_inc == 0);
            if (m_mode == 0) begin
                m_tick = 0; m_clk = 0; m_phase = 0;
                if (good) m_inc = int'(cfg_inc);
                if (en) begin
                    m_mode = 1;
                    m_cnt  = 0;
                end
            end else if (!en) begin
                if (m_mode == 1 && good) m_inc = int'(cfg_inc);
                if (m_mode == 2) m_inc = m_shadow;
                m_mode = 0; m_phase = 0; m_tick = 0; m_clk = 0;
            end else begin
                nxt     = m_phase + longint'(m_inc);
                crossed = (nxt / MODULUS) != (m_phase / MODULUS);
                m_phase = nxt;
                m_tick  = crossed;
                if (crossed) begin
                    m_clk = ~m_clk;
                    m_cnt = (m_cnt + 1) % 256;
                end
                if (m_mode == 1 && good) begin
                    m_shadow = int'(cfg_inc);
                    m_mode   = 2;
                end else if (m_mode == 2 && crossed) begin
                    m_inc  = m_shadow;
                    m_mode = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tick",      32'(tick),      32'(m_tick));
            chk("clk_out",   32'(clk_out),   32'(m_clk));
            chk("tick_cnt",  32'(tick_cnt),  32'(m_cnt));
            chk("cfg_ready", 32'(cfg_ready), 32'(m_mode != 2));
            chk("cfg_err",   32'(cfg_err),   32'(m_err));
            chk("busy",      32'(busy),      32'(m_mode != 0));
        end
    end

    task automatic step(input bit e, input bit v, input logic [ACC_W-1:0] i);
        en = e; cfg_valid = v; cfg_inc = i;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_inc = '0;
        @(negedge clk);
        @(negedge clk);
        chk_on = 1;
        chk("rst_tick_cnt", 32'(tick_cnt), 0);
        chk("rst_ready",    32'(cfg_ready), 1);
        rst = 1'b0;

        // Default increment: tick every 2 cycles
        step(1, 0, 0);
        step(1, 0, 0);
        chk("def_no_tick_e1", 32'(tick), 0);
        step(1, 0, 0);
        chk("def_first_tick", 32'(tick), 1);
        repeat (8) step(1, 0, 0);
        chk("def_cnt10", 32'(tick_cnt), 5);

        // Reset mid-run with inc 0x2000
        step(0, 0, 0);
        step(0, 1, 16'h2000);
        repeat (6) step(1, 0, 0);
        rst = 1'b1;
        step(1, 0, 0);
        rst = 1'b0;
        chk("midrst_tick",  32'(tick), 0);
        chk("midrst_clk",   32'(clk_out), 0);
        chk("midrst_cnt",   32'(tick_cnt), 0);
        chk("midrst_ready", 32'(cfg_ready), 1);
        chk("midrst_busy",  32'(busy), 0);
        repeat (3) step(1, 0, 0);
        chk("midrst_inc_default", 32'(tick), 1);

        // Fractional 0x6000: carries on run edges 3, 6, 8
        step(0, 0, 0);
        step(0, 1, 16'h6000);
        step(1, 0, 0);
        repeat (8) step(1, 0, 0);
        chk("frac_cnt8", 32'(tick_cnt), 3);

        // Reconfigure 0x2000 -> 0x8000 mid-interval
        step(0, 0, 0);
        step(0, 1, 16'h2000);
        step(1, 0, 0);
        repeat (3) step(1, 0, 0);
        step(1, 1, 16'h8000);
        chk("pend_ready", 32'(cfg_ready), 0);
        repeat (4) step(1, 0, 0);
        chk("pend_swap_tick", 32'(tick), 1);
        chk("pend_done_ready", 32'(cfg_ready), 1);
        step(1, 0, 0);
        chk("new_gap", 32'(tick), 0);
        step(1, 0, 0);
        chk("new_tick", 32'(tick), 1);

        // Zero increment rejected in IDLE and RUN
        step(0, 0, 0);
        step(0, 1, 0);
        chk("err_idle", 32'(cfg_err), 1);
        step(0, 0, 0);
        chk("err_clear", 32'(cfg_err), 0);
        step(1, 0, 0);
        step(1, 1, 0);
        chk("err_run", 32'(cfg_err), 1);
        step(1, 0, 0);
        chk("err_run_spacing", 32'(tick), 1);

        // Drop en while a config is pending, then re-enable
        step(1, 1, 16'h2000);
        chk("pend2_ready", 32'(cfg_ready), 0);
        step(0, 0, 0);
        chk("pend_drop_busy", 32'(busy), 0);
        chk("pend_drop_clk",  32'(clk_out), 0);
        step(1, 0, 0);
        repeat (7) step(1, 0, 0);
        chk("reen_no_tick", 32'(tick), 0);
        step(1, 0, 0);
        chk("reen_tick", 32'(tick), 1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [ACC_W-1:0] v;
            int sel;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: v = '0;
                1: v = 16'hFFFF;
                2: v = 16'h8000;
                3: v = 16'h0001;
                default: v = ACC_W'($urandom);
            endcase
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 39) != 0, $urandom_range(0, 9) == 0, v);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
